clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
Memory-mapped machine timer that produces the core's timer interrupt request, `timer_irpt`. It holds a free-running 64-bit `mtime` and a 64-bit `mtimecmp`. It asserts `timer_irpt` while `mtime >= mtimecmp`. It sits on the data-memory bus as a responder beside RAM; the CSR unit samples `timer_irpt` into `mip.mtip`.

Parameters:
- `RTC_DIV`, default 10: clock cycles per `mtime` increment. Legal range 1..65535.
- `ADDR_MTIMECMP`, default 32'h4000: byte offset of `mtimecmp` low word. The high word is at +4.
- `ADDR_MTIME`, default 32'hBFF8: byte offset of `mtime` low word. The high word is at +4.

Ports:
- `rst`  in  1  synchronous reset, active-low.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `timer_valid`  in  1  request strobe, one cycle per request.
- `timer_addr`  in  32  byte address; bits [15:2] decoded, [1:0] ignored.
- `timer_wdata`  in  32  write data.
- `timer_wstrb`  in  4  byte write enables; 4'h0 means read.
- `timer_rdata`  out  32  read data, valid while `timer_ready`=1.
- `timer_ready`  out  1  response strobe.
- `timer_irpt`  out  1  machine timer interrupt request, level.

Behaviour:
- Reset (`rst`=0 at an edge):
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0.
  - `timer_ready`=0, `timer_rdata`=0, `timer_irpt`=0.
  - Reset mid-transaction drops the pending response; no `timer_ready` follows.
- Prescaler:
  - 16-bit counter, 0..`RTC_DIV`-1.
  - At `RTC_DIV`-1 it wraps to 0 and generates a tick.
  - With `RTC_DIV`=1 there is a tick every cycle.
- `mtime`:
  - Increments by 1 on each tick, with full 64-bit carry from low to high word.
  - `64'hFFFF_FFFF_FFFF_FFFF` wraps to 0.
- Handshake:
  - Each cycle with `timer_valid`=1 is one request.
  - `timer_ready`=1 exactly one cycle later, with `timer_rdata` registered.
  - Back-to-back requests are legal, giving one response per cycle at 1-cycle latency.
  - `timer_ready`=0 in every cycle not following a request.
  - `timer_rdata` returns 0 when `timer_ready`=0.
- Read:
  - Returns the register word as it stood before that edge's update (pre-tick, pre-write).
  - Unmapped offsets read 0 and still get `timer_ready`.
- Write:
  - Byte-granular per `timer_wstrb` to the addressed word.
  - Unmapped offsets are ignored but still get `timer_ready`.
  - A write to either `mtime` word in a tick cycle takes precedence: that cycle's increment is lost for the whole 64-bit counter. Unwritten bytes keep their pre-edge value. The prescaler keeps running.
  - A write to `mtimecmp` takes effect at the edge.
- Interrupt:
  - `timer_irpt` is registered as the unsigned 64-bit compare (`mtime` >= `mtimecmp`) of the register values.
  - It therefore reflects any register change one cycle after that change.
  - It deasserts only when software raises `mtimecmp` above `mtime` (or `mtime` wraps).
- Software update ordering (no atomicity guaranteed): write `mtimecmp` high = all-ones, then low, then high. Reading `mtime` needs a high/low/high re-read loop.

Decomposition:
- The shared constants package holds `clint_mtime`/`clint_mtimecmp` offset constants and `init` values for the timer registers.
- The shared wires package holds `timer_reg_type` (`mtime`, `mtimecmp`, prescaler) plus `timer_in_type`/`timer_out_type` bus structs, if the bus is bundled.
- One sub-module is natural: `clint_prescaler`, a tick generator of `RTC_DIV` width holding only the counter and a tick output. The 64-bit compare and bus decode stay in the top module.

Test Plan:
- Reset then idle, `RTC_DIV`=10 → `mtime`=0 after reset; read of 0xBFF8 after 100 cycles returns 10; `timer_irpt`=0 throughout.
- Write `mtimecmp` low=5, high=0 (wstrb 4'hF) at `mtime`=0 → `timer_irpt` rises exactly one cycle after `mtime` reaches 5. A following write of `mtimecmp` high=1 drops it one cycle later.
- Write `mtime` low=32'hFFFF_FFFF, high=0, `RTC_DIV`=1 → two cycles later high reads 1 and low reads 0 or 1, verifying carry.
- Write to `mtime` low coincident with a tick → the stored value equals the written data with no +1. A byte write with wstrb 4'b0010 and wdata 32'h0000_AB00 changes only bits [15:8].
- Back-to-back reads of 0x4000, 0x1234 (unmapped), 0xBFFC on consecutive cycles → `timer_ready` high 3 consecutive cycles; data is the pre-edge value, 0, and `mtime` high.
- Assert `rst`=0 the cycle after a request → no `timer_ready`; all outputs 0; `mtimecmp` reads all-ones after reset.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// Shared constants, register bundle and helpers for the CLINT machine timer.
package clint_timer_pkg;

  // Default byte offsets of the timer registers (low words; high word at +4)
  localparam logic [31:0] CLINT_MTIMECMP = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIME    = 32'h0000_BFF8;

  // Register values after reset
  localparam logic [63:0] MTIME_INIT    = '0;
  localparam logic [63:0] MTIMECMP_INIT = '1;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
  } timer_reg_type;

  localparam timer_reg_type TIMER_REG_INIT = '{mtime: MTIME_INIT, mtimecmp: MTIMECMP_INIT};

  // Decoded target of a bus access
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  // Byte-granular merge of write data into an existing word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    merge_bytes = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) merge_bytes[8*i +: 8] = wdata[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator: one tick every RTC_DIV clock cycles.
module clint_prescaler #(
  parameter int unsigned RTC_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(RTC_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..RTC_DIV-1, wrapping on the tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp with level interrupt.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned RTC_DIV       = 10,
  parameter logic [31:0] ADDR_MTIMECMP = CLINT_MTIMECMP,
  parameter logic [31:0] ADDR_MTIME    = CLINT_MTIME
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        timer_valid,
  input  logic [31:0] timer_addr,
  input  logic [31:0] timer_wdata,
  input  logic [3:0]  timer_wstrb,
  output logic [31:0] timer_rdata,
  output logic        timer_ready,
  output logic        timer_irpt
);

  localparam logic [13:0] OFS_CMP_LO  = ADDR_MTIMECMP[15:2];
  localparam logic [13:0] OFS_CMP_HI  = OFS_CMP_LO + 14'd1;
  localparam logic [13:0] OFS_TIME_LO = ADDR_MTIME[15:2];
  localparam logic [13:0] OFS_TIME_HI = OFS_TIME_LO + 14'd1;

  timer_reg_type r;
  timer_reg_type r_nxt;
  reg_sel_e      sel;
  logic          tick;
  logic          wr_en;
  logic [31:0]   rd_word;
  logic          unused_addr;

  assign unused_addr = ^{timer_addr[31:16], timer_addr[1:0]};

  clint_prescaler #(.RTC_DIV(RTC_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Decode the addressed word
  always_comb begin
    sel = SEL_NONE;
    if      (timer_addr[15:2] == OFS_CMP_LO)  sel = SEL_CMP_LO;
    else if (timer_addr[15:2] == OFS_CMP_HI)  sel = SEL_CMP_HI;
    else if (timer_addr[15:2] == OFS_TIME_LO) sel = SEL_TIME_LO;
    else if (timer_addr[15:2] == OFS_TIME_HI) sel = SEL_TIME_HI;
  end

  // Read mux and next register state; an mtime write overrides the tick
  always_comb begin
    wr_en   = timer_valid && (timer_wstrb != '0);
    r_nxt   = r;
    rd_word = '0;
    case (sel)
      SEL_CMP_LO:  rd_word = r.mtimecmp[31:0];
      SEL_CMP_HI:  rd_word = r.mtimecmp[63:32];
      SEL_TIME_LO: rd_word = r.mtime[31:0];
      SEL_TIME_HI: rd_word = r.mtime[63:32];
      default:     rd_word = '0;
    endcase
    if (tick) r_nxt.mtime = r.mtime + 64'd1;
    if (wr_en) begin
      case (sel)
        SEL_CMP_LO:  r_nxt.mtimecmp[31:0]  = merge_bytes(r.mtimecmp[31:0], timer_wdata, timer_wstrb);
        SEL_CMP_HI:  r_nxt.mtimecmp[63:32] = merge_bytes(r.mtimecmp[63:32], timer_wdata, timer_wstrb);
        SEL_TIME_LO: r_nxt.mtime = {r.mtime[63:32], merge_bytes(r.mtime[31:0], timer_wdata, timer_wstrb)};
        SEL_TIME_HI: r_nxt.mtime = {merge_bytes(r.mtime[63:32], timer_wdata, timer_wstrb), r.mtime[31:0]};
        default:     r_nxt = r_nxt;
      endcase
    end
  end

  // Register state, bus response and interrupt compare
  always_ff @(posedge clk) begin
    if (!rst) begin
      r           <= TIMER_REG_INIT;
      timer_ready <= 1'b0;
      timer_rdata <= '0;
      timer_irpt  <= 1'b0;
    end else begin
      r           <= r_nxt;
      timer_ready <= timer_valid;
      timer_rdata <= timer_valid ? rd_word : '0;
      timer_irpt  <= (r.mtime >= r.mtimecmp);
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (RTC_DIV=10 and RTC_DIV=1) on a shared bus.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, irpt_a, irpt_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clint_timer #(.RTC_DIV(10)) dut_a (
    .rst(rst), .clk(clk), .timer_valid(valid), .timer_addr(addr),
    .timer_wdata(wdata), .timer_wstrb(wstrb),
    .timer_rdata(rdata_a), .timer_ready(ready_a), .timer_irpt(irpt_a)
  );

  clint_timer #(.RTC_DIV(1)) dut_b (
    .rst(rst), .clk(clk), .timer_valid(valid), .timer_addr(addr),
    .timer_wdata(wdata), .timer_wstrb(wstrb),
    .timer_rdata(rdata_b), .timer_ready(ready_b), .timer_irpt(irpt_b)
  );

  // Reference model: time counted in elapsed cycles since reset
  bit [63:0]   mt[2];
  bit [63:0]   mc[2];
  int unsigned age[2];
  int unsigned dv[2] = '{10, 1};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input int i, input logic [31:0] a);
    case (a[15:0] & 16'hFFFC)
      16'h4000: return mc[i][31:0];
      16'h4004: return mc[i][63:32];
      16'hBFF8: return mt[i][31:0];
      16'hBFFC: return mt[i][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input int i);
    bit [63:0] m, d;
    bit [15:0] ofs;
    bit        tk;
    if (!rst) begin
      mt[i] = 64'h0;
      mc[i] = '1;
      age[i] = 0;
    end else begin
      tk = (age[i] % dv[i]) == (dv[i] - 1);
      age[i]++;
      ofs = addr[15:0] & 16'hFFF8;
      m = 64'h0;
      for (int b = 0; b < 4; b++) if (wstrb[b]) m[8*b +: 8] = 8'hFF;
      d = {32'h0, wdata};
      if (addr[2]) begin
        m = m << 32;
        d = d << 32;
      end
      if (valid && wstrb != 4'h0 && ofs == 16'hBFF8) mt[i] = (mt[i] & ~m) | (d & m);
      else if (tk) mt[i] = mt[i] + 64'd1;
      if (valid && wstrb != 4'h0 && ofs == 16'h4000) mc[i] = (mc[i] & ~m) | (d & m);
    end
  endtask

  // One clock edge: model predicts outputs from pre-edge state, then compares
  task automatic cyc();
    bit [31:0] er[2];
    bit        ey[2];
    bit        ei[2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      ey[i] = rst && valid;
      er[i] = (rst && valid) ? model_read(i, addr) : 32'h0;
      ei[i] = rst && (mt[i] >= mc[i]);
      model_edge(i);
    end
    #1;
    check("ready_a", {63'h0, ready_a}, {63'h0, ey[0]});
    check("rdata_a", {32'h0, rdata_a}, {32'h0, er[0]});
    check("irpt_a",  {63'h0, irpt_a},  {63'h0, ei[0]});
    check("ready_b", {63'h0, ready_b}, {63'h0, ey[1]});
    check("rdata_b", {32'h0, rdata_b}, {32'h0, er[1]});
    check("irpt_b",  {63'h0, irpt_b},  {63'h0, ei[1]});
  endtask

  // Directed vectors with hand-derived expectations for both instances
  typedef struct {
    bit          rst_n;
    bit          valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rep;
    bit          chk_rd;
    bit          rdy;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    bit          chk_irq;
    bit          irq_a;
    bit          irq_b;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rn, bit v, logic [31:0] a, logic [31:0] d, logic [3:0] s, int rep,
                              bit cr, bit rdy, logic [31:0] ra, logic [31:0] rb,
                              bit ci, bit ia, bit ib);
    vec_t x;
    x = '{rst_n: rn, valid: v, addr: a, wdata: d, wstrb: s, rep: rep, chk_rd: cr, rdy: rdy,
          rd_a: ra, rd_b: rb, chk_irq: ci, irq_a: ia, irq_b: ib};
    return x;
  endfunction

  task automatic t_rst(input int n);           vq.push_back(mk(0, 0, 0, 0, 0, n, 0, 0, 0, 0, 0, 0, 0)); endtask
  task automatic t_idle(input int n);          vq.push_back(mk(1, 0, 0, 0, 0, n, 0, 0, 0, 0, 0, 0, 0)); endtask
  task automatic t_idle_irq(input int n, input bit a, input bit b);
    vq.push_back(mk(1, 0, 0, 0, 0, n, 0, 0, 0, 0, 1, a, b));
  endtask
  task automatic t_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    vq.push_back(mk(1, 1, a, d, s, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic t_wr_irq(input logic [31:0] a, input logic [31:0] d, input bit ia, input bit ib);
    vq.push_back(mk(1, 1, a, d, 4'hF, 1, 0, 0, 0, 0, 1, ia, ib));
  endtask
  task automatic t_rd(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] eb);
    vq.push_back(mk(1, 1, a, 0, 0, 1, 1, 1, ea, eb, 0, 0, 0));
  endtask

  initial begin
    // Idle count after reset; irpt stays low
    t_rst(2); t_idle_irq(100, 0, 0); t_rd(32'hBFF8, 32'd10, 32'd100);
    // Compare match at 5 then raise the high word
    t_rst(2); t_wr(32'h4000, 32'd5, 4'hF); t_wr(32'h4004, 32'd0, 4'hF);
    t_idle_irq(47, 0, 1); t_idle_irq(1, 0, 1); t_idle_irq(1, 1, 1);
    t_wr_irq(32'h4004, 32'd1, 1, 1); t_idle_irq(1, 0, 0);
    // Low-to-high carry
    t_rst(2); t_wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF); t_wr(32'hBFFC, 32'h0, 4'hF);
    t_idle(1); t_rd(32'hBFFC, 32'h0, 32'h1); t_rd(32'hBFF8, 32'hFFFF_FFFF, 32'h1);
    t_idle(5); t_rd(32'hBFFC, 32'h1, 32'h1);
    // Write on a tick cycle, then a single-byte write
    t_rst(2); t_idle(9); t_wr(32'hBFF8, 32'h1234_5678, 4'hF);
    t_rd(32'hBFF8, 32'h1234_5678, 32'h1234_5678);
    t_wr(32'hBFF8, 32'h0000_AB00, 4'b0010);
    t_rd(32'hBFF8, 32'h1234_AB78, 32'h1234_AB79);
    // Back-to-back reads incl. unmapped offset
    t_rst(2); t_wr(32'h4000, 32'hDEAD_BEEF, 4'hF);
    t_rd(32'h4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF); t_rd(32'h1234, 32'h0, 32'h0);
    t_rd(32'hBFFC, 32'h0, 32'h0);
    // Request coinciding with reset gets no response
    vq.push_back(mk(0, 1, 32'h4000, 0, 0, 1, 1, 0, 32'h0, 32'h0, 1, 0, 0));
    t_rst(1); t_rd(32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); t_rd(32'h4006, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    foreach (vq[k]) begin
      rst = vq[k].rst_n; valid = vq[k].valid; addr = vq[k].addr;
      wdata = vq[k].wdata; wstrb = vq[k].wstrb;
      repeat (vq[k].rep) cyc();
      if (vq[k].chk_rd) begin
        check($sformatf("vec%0d ready_a", k), {63'h0, ready_a}, {63'h0, vq[k].rdy});
        check($sformatf("vec%0d ready_b", k), {63'h0, ready_b}, {63'h0, vq[k].rdy});
        check($sformatf("vec%0d rdata_a", k), {32'h0, rdata_a}, {32'h0, vq[k].rd_a});
        check($sformatf("vec%0d rdata_b", k), {32'h0, rdata_b}, {32'h0, vq[k].rd_b});
      end
      if (vq[k].chk_irq) begin
        check($sformatf("vec%0d irpt_a", k), {63'h0, irpt_a}, {63'h0, vq[k].irq_a});
        check($sformatf("vec%0d irpt_b", k), {63'h0, irpt_b}, {63'h0, vq[k].irq_b});
      end
    end

    // Randomized traffic against the model
    rst = 1'b0; valid = 1'b0; wstrb = '0;
    cyc(); cyc();
    for (int n = 0; n < 3000; n++) begin
      int unsigned s;
      rst = ($urandom_range(0, 199) != 0);
      valid = $urandom_range(0, 1);
      s = $urandom_range(0, 4);
      case (s)
        0: addr = 32'h4000;
        1: addr = 32'h4004;
        2: addr = 32'hBFF8;
        3: addr = 32'hBFFC;
        default: addr = $urandom;
      endcase
      if (s < 4) addr = addr | 32'($urandom_range(0, 3));
      wstrb = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wdata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 400)) : $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
